// File: rtl/serial_pattern_tx_if.sv
// Serial pattern transmitter port bundle.
// master drives requests, slave is the transmitter.
interface serial_pattern_tx_if #(
  parameter int WIDTH   = 4,
  parameter int COUNT_W = 4
);
  logic               start;
  logic [WIDTH-1:0]   data;
  logic [COUNT_W-1:0] reps;
  logic               abort;
  logic               w;
  logic               valid;
  logic               frame_last;
  logic               busy;
  logic               done;

  modport master (
    output start, data, reps, abort,
    input  w, valid, frame_last, busy, done
  );

  modport slave (
    input  start, data, reps, abort,
    output w, valid, frame_last, busy, done
  );
endinterface

// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: shifts a WIDTH-bit frame out MSB
// first, repeated reps+1 times back to back, registered outputs.
module serial_pattern_tx #(
  parameter int WIDTH   = 4,
  parameter int COUNT_W = 4
) (
  input  logic Clock,
  input  logic Resetn,
  serial_pattern_tx_if.slave bus
);
  localparam int BW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   sreg_q, sreg_d;
  logic [WIDTH-1:0]   copy_q, copy_d;
  logic [BW-1:0]      bcnt_q, bcnt_d;
  logic [COUNT_W-1:0] frm_q, frm_d;

  logic w_d, valid_d, last_d, busy_d, done_d;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q        <= IDLE;
      sreg_q         <= '0;
      copy_q         <= '0;
      bcnt_q         <= '0;
      frm_q          <= '0;
      bus.w          <= 1'b0;
      bus.valid      <= 1'b0;
      bus.frame_last <= 1'b0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
    end else begin
      state_q        <= state_d;
      sreg_q         <= sreg_d;
      copy_q         <= copy_d;
      bcnt_q         <= bcnt_d;
      frm_q          <= frm_d;
      bus.w          <= w_d;
      bus.valid      <= valid_d;
      bus.frame_last <= last_d;
      bus.busy       <= busy_d;
      bus.done       <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    copy_d  = copy_q;
    bcnt_d  = bcnt_q;
    frm_d   = frm_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = SHIFT;
          sreg_d  = bus.data;
          copy_d  = bus.data;
          bcnt_d  = LAST;
          frm_d   = bus.reps;
        end
      end
      SHIFT: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (bcnt_q != '0) begin
          sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
          bcnt_d = bcnt_q - BW'(1);
        end else if (frm_q != '0) begin
          // reload for the next frame with no idle gap
          frm_d  = frm_q - COUNT_W'(1);
          sreg_d = copy_q;
          bcnt_d = LAST;
        end else begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // outputs are decoded from next state so they land in flops
  always_comb begin
    valid_d = (state_d == SHIFT);
    busy_d  = (state_d == SHIFT) || (state_d == DONE);
    done_d  = (state_d == DONE);
    w_d     = valid_d && sreg_d[WIDTH-1];
    last_d  = valid_d && (bcnt_d == '0);
  end
endmodule

// File: tb/tb_serial_pattern_tx.sv
// Directed bench for serial_pattern_tx.
// Output vector order: {w, valid, frame_last, busy, done}.
module tb_serial_pattern_tx;
  logic Clock;
  logic Resetn;
  int   vectors;
  int   miscompares;

  serial_pattern_tx_if #(.WIDTH(4), .COUNT_W(4)) bus ();

  serial_pattern_tx #(.WIDTH(4), .COUNT_W(4)) dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .bus    (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic logic [4:0] outs();
    return {bus.w, bus.valid, bus.frame_last, bus.busy, bus.done};
  endfunction

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [4:0] exp);
    logic [4:0] got;
    got = outs();
    vectors++;
    assert (got === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask

  initial begin
    logic [11:0] p12;
    logic [3:0]  p4;
    logic [3:0]  ph;
    vectors     = 0;
    miscompares = 0;
    Resetn      = 1'b0;
    bus.start   = 1'b0;
    bus.data    = '0;
    bus.reps    = '0;
    bus.abort   = 1'b0;
    #12;
    chk("reset", 5'b00000);
    Resetn = 1'b1;
    tick();
    chk("idle_after_reset", 5'b00000);

    // 1: single frame 1101
    bus.data  = 4'b1101;
    bus.reps  = 4'd0;
    bus.start = 1'b1;
    tick(); bus.start = 1'b0;
    chk("t1_b1", 5'b11010);
    tick(); chk("t1_b2", 5'b11010);
    tick(); chk("t1_b3", 5'b01010);
    tick(); chk("t1_b4", 5'b11110);
    tick(); chk("t1_done", 5'b00011);
    tick(); chk("t1_idle", 5'b00000);

    // 2: three frames, inputs change after capture
    bus.data  = 4'b1101;
    bus.reps  = 4'd2;
    bus.start = 1'b1;
    p12 = 12'b1101_1101_1101;
    tick();
    bus.start = 1'b0;
    bus.data  = 4'b0000;
    bus.reps  = 4'd0;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) tick();
      chk($sformatf("t2_b%0d", i + 1),
          {p12[11-i], 1'b1, (i % 4 == 3), 1'b1, 1'b0});
    end
    tick(); chk("t2_done", 5'b00011);
    tick(); chk("t2_idle", 5'b00000);

    // 3: second start during shifting is ignored
    bus.data  = 4'b1101;
    bus.start = 1'b1;
    tick(); chk("t3_b1", 5'b11010);
    bus.data = 4'b0000;
    tick(); chk("t3_b2", 5'b11010);
    tick(); chk("t3_b3", 5'b01010);
    tick(); chk("t3_b4", 5'b11110);
    tick(); chk("t3_done", 5'b00011);
    bus.start = 1'b0;
    tick(); chk("t3_idle", 5'b00000);

    // 4: abort during bit 2, then restart immediately
    bus.data  = 4'b1101;
    bus.start = 1'b1;
    tick(); chk("t4_b1", 5'b11010);
    bus.start = 1'b0;
    tick(); chk("t4_b2", 5'b11010);
    bus.abort = 1'b1;
    tick(); chk("t4_abort", 5'b00000);
    bus.abort = 1'b0;
    bus.data  = 4'b1010;
    bus.start = 1'b1;
    tick(); chk("t4_rs_b1", 5'b11010);
    bus.start = 1'b0;
    tick(); chk("t4_rs_b2", 5'b01010);
    tick(); chk("t4_rs_b3", 5'b11010);
    tick(); chk("t4_rs_b4", 5'b01110);
    tick(); chk("t4_rs_done", 5'b00011);
    tick(); chk("t4_rs_idle", 5'b00000);

    // abort in IDLE ignored; abort on last bit beats done
    bus.data  = 4'b0110;
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick(); chk("t4b_b1", 5'b01010);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    tick(); chk("t4b_b2", 5'b11010);
    tick(); chk("t4b_b3", 5'b11010);
    tick(); chk("t4b_b4", 5'b01110);
    bus.abort = 1'b1;
    tick(); chk("t4b_nodone", 5'b00000);
    bus.abort = 1'b0;
    tick(); chk("t4b_idle", 5'b00000);

    // 5: asynchronous reset mid-frame
    bus.data  = 4'b1111;
    bus.reps  = 4'd1;
    bus.start = 1'b1;
    tick(); chk("t5_b1", 5'b11010);
    bus.start = 1'b0;
    tick(); chk("t5_b2", 5'b11010);
    #2 Resetn = 1'b0;
    #1 chk("t5_async", 5'b00000);
    tick(); chk("t5_hold", 5'b00000);
    #2 Resetn = 1'b1;
    tick(); chk("t5_idle1", 5'b00000);
    tick(); chk("t5_idle2", 5'b00000);

    // 6: start held high, six-cycle period
    bus.data  = 4'b1010;
    bus.reps  = 4'd0;
    bus.start = 1'b1;
    p4 = 4'b1010;
    for (int c = 0; c < 20; c++) begin
      tick();
      ph = 4'(c % 6);
      if (ph < 4)
        chk($sformatf("t6_c%0d", c),
            {p4[3-ph], 1'b1, (ph == 4'd3), 1'b1, 1'b0});
      else if (ph == 4)
        chk($sformatf("t6_c%0d", c), 5'b00011);
      else
        chk($sformatf("t6_c%0d", c), 5'b00000);
    end
    bus.start = 1'b0;
    while (outs() !== 5'b00000 && vectors < 100000) tick();
    tick(); chk("t6_idle", 5'b00000);

    // maximum repeat: 16 frames, no wrap
    bus.data  = 4'b1001;
    bus.reps  = 4'd15;
    bus.start = 1'b1;
    p4 = 4'b1001;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (i > 0) tick();
      chk($sformatf("tmax_b%0d", i + 1),
          {p4[3-(i%4)], 1'b1, (i % 4 == 3), 1'b1, 1'b0});
    end
    tick(); chk("tmax_done", 5'b00011);
    tick(); chk("tmax_idle", 5'b00000);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/serial_pattern_tx.md
Name: serial_pattern_tx

Overview:
Serial pattern transmitter. It drives the single-bit w stream consumed by the team's Mealy sequence detectors. It loads a WIDTH-bit pattern, shifts it out MSB first, one bit per clock, and can repeat the frame back-to-back a programmed number of times. Used as the on-chip stimulus source for detector blocks and as the transmit end of the serial pattern link.

Parameters:
WIDTH, 4, pattern length in bits (must be >= 2)
COUNT_W, 4, width of the repeat count

Ports:
Clock  input  1  system clock, rising edge
Resetn  input  1  asynchronous active-low reset
start  input  1  request to begin transmission; sampled only in IDLE
data  input  WIDTH  pattern, captured on the accepting edge
repeat  input  COUNT_W  extra frames; total frames = repeat+1, captured with data
abort  input  1  synchronous cancel of an active transmission
w  output  1  serial data, MSB of each frame first
valid  output  1  w carries a pattern bit this cycle
frame_last  output  1  w carries bit 0 of a frame
busy  output  1  transmitter not in IDLE
done  output  1  one-cycle pulse after the final bit of the final frame

Behaviour:
- One clock. Reset is asynchronous and active-low: Resetn low forces state IDLE immediately and clears all registers. Outputs w, valid, frame_last, busy and done all read 0 during and after reset.
- All outputs are registered (Moore). There are no combinational paths from inputs to outputs.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - Outputs are all 0.
  - start=1 on an edge: capture data into the shift register and into a reload copy, capture repeat into the frame counter, and load the bit counter with WIDTH-1. Go to SHIFT.
- SHIFT:
  - Each cycle: w = current MSB, valid=1, busy=1.
  - Each edge shifts left by one and decrements the bit counter.
  - frame_last=1 in the cycle the bit counter is 0.
  - At end of frame, if the frame counter is not 0: decrement it, reload the shift register from the copy, and reset the bit counter. The next frame follows with no gap.
  - At end of frame, if the frame counter is 0: go to DONE.
- DONE: done=1 and busy=1 for exactly one cycle, with w=0 and valid=0. Then return to IDLE.
- Latency: with start sampled at edge k, the first bit appears on w after edge k. Each bit is held for exactly one cycle. A frame occupies WIDTH cycles. done appears after edge k + (repeat+1)*WIDTH.
- start is ignored in SHIFT and DONE. There is no queuing. With start held high continuously, a new transmission begins after one IDLE cycle following DONE.
- data and repeat changing after capture have no effect on the transmission in progress.
- abort=1 in SHIFT: the next edge goes to IDLE, all outputs become 0, and done is not pulsed. abort in IDLE or DONE is ignored. Simultaneous abort and end-of-last-frame: abort wins, with no done.
- repeat = 2^COUNT_W-1 is legal: the frame counter decrements without wrap-around.
- Undefined state encodings return to IDLE on the next edge.

Test Plan:
1. Reset, then data=4'b1101, repeat=0, start for 1 cycle -> w=1,1,0,1 on 4 consecutive cycles; valid=1111; frame_last only on the 4th; done pulse on the 5th cycle; busy high 5 cycles; then IDLE. Feeding w to the 1101 detector gives z=1 on the 4th bit.
2. data=1101, repeat=2 -> 12 contiguous bits 110111011101; frame_last on bits 4, 8, 12; a single done pulse after bit 12.
3. Start with data=1101, then at bit 2 assert start with data=0000 -> the second start is ignored; the output stays 1101; only one done pulse.
4. abort asserted during bit 2 -> the following cycle has busy=0, w=0, valid=0; no done; a new start is accepted immediately.
5. Resetn driven low mid-frame, between clock edges -> all outputs 0 at once; after release, IDLE holds with no output until start.
6. start held high for 20 cycles with data=1010, repeat=0 -> the frame repeats every 6 cycles (4 bits, DONE, IDLE).
